// File: rtl/tictac_pkg.sv
// Shared tic-tac-toe types and board geometry, used by the cursor and color stages.
package tictac_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  typedef enum logic {X = 1'b0, O = 1'b1} player_t;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned BOARD_X0  = 170;
  localparam int unsigned BOARD_Y0  = 90;
  localparam int unsigned CELL_SIZE = 100;

endpackage

// File: rtl/debounce_edge.sv
// Button debouncer: accepts a new level after DEBOUNCE_CYCLES stable cycles and
// emits a one-cycle pulse on each accepted 0->1 change.
module debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
      // Any sample matching the accepted level restarts the stability count.
      if (i_btn == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt >= LAST) begin
        r_level <= i_btn;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/cursor_move_ctrl.sv
// Cursor/move-request stage: debounced buttons drive a cursor over the 3x3 board,
// a registered highlight box, and a held move request handshaked with the game.
module cursor_move_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned BOARD_X0        = tictac_pkg::BOARD_X0,
  parameter int unsigned BOARD_Y0        = tictac_pkg::BOARD_Y0,
  parameter int unsigned CELL_SIZE       = tictac_pkg::CELL_SIZE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn_next,
  input  logic        i_btn_sel,
  input  logic [8:0]  i_occupied,
  input  logic        i_game_over,
  input  logic        i_move_ack,
  output logic        o_move_valid,
  output logic [3:0]  o_move_pos,
  output logic        o_move_player,
  output logic [3:0]  o_cursor,
  output logic [15:0] o_start_x,
  output logic [15:0] o_end_x,
  output logic [9:0]  o_start_y,
  output logic [9:0]  o_end_y
);

  import tictac_pkg::*;

  logic w_next_press, w_sel_press;
  logic w_next_level, w_sel_level;
  logic w_unused_levels;

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn_next),
    .o_level (w_next_level),
    .o_press (w_next_press)
  );

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn_sel),
    .o_level (w_sel_level),
    .o_press (w_sel_press)
  );

  assign w_unused_levels = w_next_level ^ w_sel_level;

  state_t     r_state, w_state_nxt;
  player_t    r_turn, w_turn_nxt;
  logic [3:0] r_cursor, w_cursor_nxt;
  logic       r_move_valid, w_valid_nxt;
  logic [3:0] r_move_pos, w_pos_nxt;
  logic       r_move_player, w_player_nxt;

  // Next-free search: rotate the free map so bit k is cell (cursor+1+k) mod 9,
  // then take the lowest set bit. Only offsets 1..8 matter; the cursor never
  // lands back on itself.
  logic [8:0]  w_taken;
  logic [17:0] w_free2;
  logic [7:0]  w_rot;
  logic [3:0]  w_offset;
  logic        w_found;
  logic [4:0]  w_sum;
  logic [3:0]  w_next_cell;

  always_comb begin
    w_taken = i_occupied;
    if (r_state == REQ) begin
      w_taken = i_occupied | (9'd1 << r_cursor);
    end
    w_free2  = {~w_taken, ~w_taken};
    w_rot    = 8'(w_free2 >> (r_cursor + 4'd1));
    w_found  = 1'b0;
    w_offset = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found  = 1'b1;
        w_offset = 4'(k);
      end
    end
    w_sum = 5'(r_cursor) + 5'd1 + 5'(w_offset);
    if (w_sum >= 5'(NUM_CELLS)) begin
      w_sum = w_sum - 5'(NUM_CELLS);
    end
    w_next_cell = w_found ? w_sum[3:0] : r_cursor;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cursor_nxt = r_cursor;
    w_turn_nxt   = r_turn;
    w_valid_nxt  = r_move_valid;
    w_pos_nxt    = r_move_pos;
    w_player_nxt = r_move_player;
    if (i_game_over) begin
      w_state_nxt = DONE;
      w_valid_nxt = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // Sel wins over a simultaneous next, even when the sel is refused.
          if (w_sel_press) begin
            if (!i_occupied[r_cursor]) begin
              w_state_nxt  = REQ;
              w_valid_nxt  = 1'b1;
              w_pos_nxt    = r_cursor;
              w_player_nxt = r_turn;
            end
          end else if (w_next_press) begin
            w_cursor_nxt = w_next_cell;
          end
        end
        REQ: begin
          if (i_move_ack) begin
            w_state_nxt  = IDLE;
            w_valid_nxt  = 1'b0;
            w_turn_nxt   = player_t'(~r_turn);
            w_cursor_nxt = w_next_cell;
          end
        end
        DONE: begin
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_turn        <= X;
      r_cursor      <= 4'd0;
      r_move_valid  <= 1'b0;
      r_move_pos    <= 4'd0;
      r_move_player <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_turn        <= w_turn_nxt;
      r_cursor      <= w_cursor_nxt;
      r_move_valid  <= w_valid_nxt;
      r_move_pos    <= w_pos_nxt;
      r_move_player <= w_player_nxt;
    end
  end

  logic [1:0] w_row, w_col;

  always_comb begin
    w_row = 2'd0;
    w_col = 2'd0;
    unique case (r_cursor)
      4'd0: begin w_row = 2'd0; w_col = 2'd0; end
      4'd1: begin w_row = 2'd0; w_col = 2'd1; end
      4'd2: begin w_row = 2'd0; w_col = 2'd2; end
      4'd3: begin w_row = 2'd1; w_col = 2'd0; end
      4'd4: begin w_row = 2'd1; w_col = 2'd1; end
      4'd5: begin w_row = 2'd1; w_col = 2'd2; end
      4'd6: begin w_row = 2'd2; w_col = 2'd0; end
      4'd7: begin w_row = 2'd2; w_col = 2'd1; end
      4'd8: begin w_row = 2'd2; w_col = 2'd2; end
      default: begin w_row = 2'd0; w_col = 2'd0; end
    endcase
  end

  logic [15:0] r_start_x, r_end_x;
  logic [9:0]  r_start_y, r_end_y;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_start_x <= 16'(BOARD_X0);
      r_end_x   <= 16'(BOARD_X0 + CELL_SIZE - 1);
      r_start_y <= 10'(BOARD_Y0);
      r_end_y   <= 10'(BOARD_Y0 + CELL_SIZE - 1);
    end else begin
      r_start_x <= 16'(BOARD_X0 + w_col * CELL_SIZE);
      r_end_x   <= 16'(BOARD_X0 + w_col * CELL_SIZE + CELL_SIZE - 1);
      r_start_y <= 10'(BOARD_Y0 + w_row * CELL_SIZE);
      r_end_y   <= 10'(BOARD_Y0 + w_row * CELL_SIZE + CELL_SIZE - 1);
    end
  end

  assign o_move_valid  = r_move_valid;
  assign o_move_pos    = r_move_pos;
  assign o_move_player = r_move_player;
  assign o_cursor      = r_cursor;
  assign o_start_x     = r_start_x;
  assign o_end_x       = r_end_x;
  assign o_start_y     = r_start_y;
  assign o_end_y       = r_end_y;

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Self-checking bench for cursor_move_ctrl with a scoreboard of expected snapshots.
module tb_cursor_move_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_next = 1'b0;
  logic        btn_sel = 1'b0;
  logic [8:0]  occupied = 9'd0;
  logic        game_over = 1'b0;
  logic        move_ack = 1'b0;
  logic        move_valid;
  logic [3:0]  move_pos;
  logic        move_player;
  logic [3:0]  cursor;
  logic [15:0] start_x, end_x;
  logic [9:0]  start_y, end_y;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int unsigned cur;
    int unsigned valid;
    int unsigned pos;
    int unsigned player;
  } exp_t;

  exp_t sb_q[$];

  cursor_move_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .BOARD_X0        (170),
    .BOARD_Y0        (90),
    .CELL_SIZE       (100)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_btn_next    (btn_next),
    .i_btn_sel     (btn_sel),
    .i_occupied    (occupied),
    .i_game_over   (game_over),
    .i_move_ack    (move_ack),
    .o_move_valid  (move_valid),
    .o_move_pos    (move_pos),
    .o_move_player (move_player),
    .o_cursor      (cursor),
    .o_start_x     (start_x),
    .o_end_x       (end_x),
    .o_start_y     (start_y),
    .o_end_y       (end_y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int unsigned c, input int unsigned v,
                          input int unsigned p, input int unsigned pl);
    exp_t e;
    e.cur = c; e.valid = v; e.pos = p; e.player = pl;
    sb_q.push_back(e);
  endtask

  // Pops the oldest expectation and compares it against the current outputs.
  task automatic compare_out(input string tag);
    exp_t e;
    int unsigned sx, sy;
    check_val({tag, "_sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e  = sb_q.pop_front();
      sx = 170 + (e.cur % 3) * 100;
      sy = 90 + (e.cur / 3) * 100;
      check_val({tag, "_cursor"}, cursor, e.cur);
      check_val({tag, "_valid"}, move_valid, e.valid);
      check_val({tag, "_startx"}, start_x, sx);
      check_val({tag, "_endx"}, end_x, sx + 99);
      check_val({tag, "_starty"}, start_y, sy);
      check_val({tag, "_endy"}, end_y, sy + 99);
      if (e.valid != 0) begin
        check_val({tag, "_pos"}, move_pos, e.pos);
        check_val({tag, "_player"}, move_player, e.player);
      end
    end
  endtask

  task automatic press(input logic nxt, input logic sel);
    btn_next = nxt;
    btn_sel  = sel;
    tick(8);
    btn_next = 1'b0;
    btn_sel  = 1'b0;
    tick(8);
  endtask

  task automatic ack();
    move_ack = 1'b1;
    tick(1);
    move_ack = 1'b0;
    tick(4);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    tick(1);
    push_exp(0, 0, 0, 0);
    compare_out("reset");

    occupied = 9'b000000110;
    press(1'b1, 1'b0);
    push_exp(3, 0, 0, 0);
    compare_out("skip_occ");

    btn_next = 1'b1;
    tick(3);
    btn_next = 1'b0;
    tick(8);
    push_exp(3, 0, 0, 0);
    compare_out("glitch");

    press(1'b1, 1'b0);
    push_exp(4, 0, 0, 0);
    compare_out("next_to4");

    press(1'b0, 1'b1);
    push_exp(4, 1, 4, 0);
    compare_out("sel4");
    tick(5);
    push_exp(4, 1, 4, 0);
    compare_out("sel4_hold");
    press(1'b1, 1'b0);
    push_exp(4, 1, 4, 0);
    compare_out("req_ignore_next");

    occupied = 9'b000010110;
    ack();
    push_exp(5, 0, 0, 0);
    compare_out("ack4");

    press(1'b0, 1'b1);
    push_exp(5, 1, 5, 1);
    compare_out("sel5_player_o");
    occupied = 9'b000110110;
    ack();
    push_exp(6, 0, 0, 0);
    compare_out("ack5");

    occupied = 9'b001110110;
    press(1'b0, 1'b1);
    push_exp(6, 0, 0, 0);
    compare_out("sel_occupied");

    press(1'b1, 1'b0);
    push_exp(7, 0, 0, 0);
    compare_out("next_to7");
    press(1'b1, 1'b1);
    push_exp(7, 1, 7, 0);
    compare_out("sel_and_next");
    occupied = 9'b011110110;
    ack();
    push_exp(8, 0, 0, 0);
    compare_out("ack7");

    occupied = 9'h0FF;
    press(1'b1, 1'b0);
    push_exp(8, 0, 0, 0);
    compare_out("wrap_no_free");
    occupied = 9'h1FF;
    press(1'b1, 1'b0);
    push_exp(8, 0, 0, 0);
    compare_out("full_board");

    occupied = 9'h0FF;
    press(1'b0, 1'b1);
    push_exp(8, 1, 8, 1);
    compare_out("sel8");
    game_over = 1'b1;
    ack();
    push_exp(8, 0, 0, 0);
    compare_out("game_over");
    check_val("game_over_player", move_player, 1);
    game_over = 1'b0;
    occupied  = 9'd0;
    press(1'b1, 1'b0);
    push_exp(8, 0, 0, 0);
    compare_out("done_ignore_next");
    press(1'b0, 1'b1);
    push_exp(8, 0, 0, 0);
    compare_out("done_ignore_sel");

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    push_exp(0, 0, 0, 0);
    compare_out("rerst");
    check_val("rerst_pos", move_pos, 0);
    check_val("rerst_player", move_player, 0);

    press(1'b0, 1'b1);
    push_exp(0, 1, 0, 0);
    compare_out("sel0_new_game");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    push_exp(0, 0, 0, 0);
    compare_out("rst_mid_req");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cursor_move_ctrl.md
# cursor_move_ctrl

Upstream stage of the tic-tac-toe game logic. It turns the two synchronised push-buttons into three things:
- a debounced cursor over the 3×3 board;
- a highlight box for the color stage;
- a handshaked move request (position plus player) for the game engine.

It tracks whose turn it is, skips occupied cells, and freezes once the game reports it is over.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000, cycles a button level must be stable before it is accepted (10 ms at 25 MHz)
- BOARD_X0, 170, left pixel of cell column 0
- BOARD_Y0, 90, top pixel of cell row 0
- CELL_SIZE, 100, cell width and height in pixels

Ports:
- clk  in  1  25 MHz pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- btn_next  in  1  synchronised "move cursor" button, active-high
- btn_sel  in  1  synchronised "place mark" button, active-high
- occupied  in  9  board occupancy from the game; bit i set means cell i is taken
- game_over  in  1  level from the game: win or draw reached
- move_ack  in  1  one-cycle acknowledge from the game for the current request
- move_valid  out  1  move request pending
- move_pos  out  4  requested cell, 0..8
- move_player  out  1  0 = X, 1 = O
- cursor  out  4  current cell, 0..8
- startX, endX  out  16  highlight box horizontal bounds
- startY, endY  out  10  highlight box vertical bounds

## Operation
Button handling:
- Each button passes through a debouncer.
- After DEBOUNCE_CYCLES consecutive cycles at a new level, the accepted level updates.
- A 0→1 change of the accepted level emits a one-cycle press pulse.

State machine, states IDLE, REQ, DONE:
- **IDLE, next pulse:** cursor moves to the next free cell in ascending order, wrapping 8→0. Cells set in `occupied` are skipped. If no cell is free, the cursor is unchanged.
- **IDLE, sel pulse on a free cursor cell:** go to REQ. Set move_valid=1, move_pos=cursor, move_player=turn.
- **IDLE, sel pulse on an occupied cell:** ignored; no state change.
- **IDLE, sel and next pulses in the same cycle:** sel wins and next is dropped.
- **REQ:**
  - move_valid, move_pos and move_player are held stable.
  - All button pulses are ignored.
  - On move_ack: move_valid clears, turn toggles, cursor advances to the next free cell, and the state returns to IDLE. The next-free search treats the just-played cell as occupied.
- **Any state, game_over=1:** go to DONE and clear move_valid. This takes priority over move_ack in the same cycle.
- **DONE:** all buttons are ignored. The block leaves DONE only through rst.

Highlight box:
- Registered from the cursor, with row = cursor/3 and col = cursor%3.
- startX = BOARD_X0 + col·CELL_SIZE, endX = startX + CELL_SIZE − 1.
- startY = BOARD_Y0 + row·CELL_SIZE, endY = startY + CELL_SIZE − 1.
- Compute with constant multiplies only (no divider). A 9-entry case is acceptable.

## Timing
Reset values:
- Outputs: cursor=0, move_valid=0, move_pos=0, move_player=0, box = cell 0 (170,269,90,189 with defaults).
- Internal: turn=X, state IDLE, debouncers cleared with accepted level 0.

Latency:
- A raw press is accepted after DEBOUNCE_CYCLES stable cycles. The pulse is seen one cycle later.
- Cursor update: 1 cycle after the pulse.
- Box update: 1 cycle after the cursor.
- move_valid: 1 cycle after the sel pulse.
- Clear after ack: move_valid drops on the cycle after the move_ack cycle.

Handshake:
- move_ack is only meaningful while move_valid=1; it is ignored otherwise.
- The game must not see the request change before ack.

Reset mid-request: move_valid clears on the next edge and the pending move is lost.

## Structure
- **Package tictac_pkg:**
  - `state_t` enum {IDLE, REQ, DONE}.
  - `player_t` (X=0, O=1).
  - Constants NUM_CELLS=9, BOARD_X0, BOARD_Y0, CELL_SIZE. These are shared with the color controller.
- **Sub-module debounce_edge (one instance per button):**
  - Stability counter sized $clog2(DEBOUNCE_CYCLES+1).
  - Outputs the accepted level and a press pulse.
- **Next-free search:** combinational rotate of the occupancy vector plus a priority encode, in the top block.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- **Reset:** rst for 2 cycles → cursor=0, move_valid=0, box=(170,269,90,189).
- **Skip occupied:** occupied=9'b000000110, cursor=0, one next press → cursor=3. A glitch shorter than 4 cycles → no change.
- **Select and ack:** free cell 4, sel press → move_valid=1, pos=4, player=0 held for 5 cycles without ack. Then move_ack → move_valid=0, next move_player=1, cursor=5.
- **Occupied select:** sel on an occupied cursor cell → move_valid stays 0. Sel and next pulsing in the same cycle on a free cell → request issued, cursor unchanged.
- **Wrap and full board:** cursor=8 with cells 0..7 occupied, next → cursor=8 (no free alternative). With occupied=9'h1FF, next → cursor unchanged.
- **game_over:** game_over raised during REQ, together with move_ack → DONE, move_valid=0, turn not toggled, buttons ignored until rst.
